// File: rtl/aes_sbox_pkg.sv
// AES S-box tables split into four 64-entry slices.
// Shared types, constants and a reference lookup.
package aes_sbox_pkg;

    localparam int BYTE_W   = 8;
    localparam int SLICES   = 4;
    localparam int SLICE_AW = 6;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef byte_t slice_t [64];

    // Slice k holds S-box entries 64*k .. 64*k+63.
    localparam slice_t SBOX_FWD_SLICE [SLICES] = '{
        '{
            8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
            8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
            8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
            8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
            8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
            8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
            8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
            8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75
        },
        '{
            8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
            8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
            8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
            8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
            8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
            8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
            8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
            8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2
        },
        '{
            8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
            8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
            8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
            8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
            8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
            8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
            8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
            8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08
        },
        '{
            8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
            8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
            8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
            8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
            8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
            8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
            8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
            8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
        }
    };

    localparam slice_t SBOX_INV_SLICE [SLICES] = '{
        '{
            8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
            8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
            8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
            8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
            8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
            8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
            8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
            8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25
        },
        '{
            8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
            8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
            8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
            8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
            8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
            8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
            8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
            8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b
        },
        '{
            8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
            8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
            8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
            8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
            8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
            8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
            8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
            8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4
        },
        '{
            8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
            8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
            8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
            8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
            8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
            8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
            8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
            8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
        }
    };

    function automatic byte_t sbox_ref(input byte_t b, input logic inv);
        byte_t r;
        if (inv) r = SBOX_INV_SLICE[b[7:6]][b[5:0]];
        else     r = SBOX_FWD_SLICE[b[7:6]][b[5:0]];
        return r;
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One SubBytes lane: S1 registers four slice reads, S2 muxes by byte[7:6].
// Ports: clk, rst, s1_en/s2_en stage enables, in_byte/in_inv, out_byte.
// AES_INV_SBOX_EN adds the inverse slice set selected by in_inv.
module sbox_lane
    import aes_sbox_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              s1_en,
    input  logic              s2_en,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_inv,
    output logic [BYTE_W-1:0] out_byte
);

    (* romstyle = "logic" *) byte_t fwd_rd [SLICES];
    byte_t fwd_q [SLICES];
    byte_t fwd_d [SLICES];
    logic [1:0] sel_q, sel_d;
    byte_t out_q, out_d;
    byte_t pick;

`ifdef AES_INV_SBOX_EN
    (* romstyle = "logic" *) byte_t inv_rd [SLICES];
    byte_t inv_q [SLICES];
    byte_t inv_d [SLICES];
    logic invf_q, invf_d;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    always_comb begin
        for (int k = 0; k < SLICES; k++) begin
            fwd_rd[k] = SBOX_FWD_SLICE[k][in_byte[SLICE_AW-1:0]];
            fwd_d[k]  = s1_en ? fwd_rd[k] : fwd_q[k];
        end
        sel_d = s1_en ? in_byte[7:6] : sel_q;
    end

`ifdef AES_INV_SBOX_EN
    always_comb begin
        for (int k = 0; k < SLICES; k++) begin
            inv_rd[k] = SBOX_INV_SLICE[k][in_byte[SLICE_AW-1:0]];
            inv_d[k]  = s1_en ? inv_rd[k] : inv_q[k];
        end
        invf_d = s1_en ? in_inv : invf_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SLICES; k++) inv_q[k] <= '0;
            invf_q <= 1'b0;
        end else begin
            for (int k = 0; k < SLICES; k++) inv_q[k] <= inv_d[k];
            invf_q <= invf_d;
        end
    end
`endif

    // Second level: pick the slice addressed by the upper two bits.
    always_comb begin
        pick = fwd_q[sel_q];
`ifdef AES_INV_SBOX_EN
        if (invf_q) pick = inv_q[sel_q];
`endif
        out_d = s2_en ? pick : out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SLICES; k++) fwd_q[k] <= '0;
            sel_q <= '0;
            out_q <= '0;
        end else begin
            for (int k = 0; k < SLICES; k++) fwd_q[k] <= fwd_d[k];
            sel_q <= sel_d;
            out_q <= out_d;
        end
    end

    assign out_byte = out_q;

endmodule

// File: rtl/sub_bytes_pipe.sv
// Multi-lane elastic AES SubBytes, 2-stage valid/ready pipeline.
// Ports: in_valid/in_ready/in_data/in_inv/in_tag, out_valid/out_ready/
// out_data/out_tag; clk with sync active-high rst.
// AES_INV_SBOX_EN enables per-beat inverse S-box via in_inv.
module sub_bytes_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 16,
    parameter int TAG_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BYTE_W*LANES-1:0] in_data,
    input  logic                    in_inv,
    input  logic [TAG_W-1:0]        in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BYTE_W*LANES-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag
);

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;
    logic s1_adv, s2_adv;

    // A stage advances when empty or when the stage behind it drains.
    always_comb begin
        s2_adv = !v2_q || out_ready;
        s1_adv = !v1_q || s2_adv;
        v1_d   = s1_adv ? in_valid : v1_q;
        tag1_d = s1_adv ? in_tag : tag1_q;
        v2_d   = s2_adv ? v1_q : v2_q;
        tag2_d = s2_adv ? tag1_q : tag2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q   <= 1'b0;
            v2_q   <= 1'b0;
            tag1_q <= '0;
            tag2_q <= '0;
        end else begin
            v1_q   <= v1_d;
            v2_q   <= v2_d;
            tag1_q <= tag1_d;
            tag2_q <= tag2_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = v2_q;
    assign out_tag   = tag2_q;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sbox_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .s1_en    (s1_adv),
            .s2_en    (s2_adv),
            .in_byte  (in_data[BYTE_W*i +: BYTE_W]),
            .in_inv   (in_inv),
            .out_byte (out_data[BYTE_W*i +: BYTE_W])
        );
    end

endmodule
